// File: rtl/input_port_vc_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_vc_buffer_if
//  Description : Port bundle of one router input-port VC buffer.
//                master : upstream link + switch-traversal stage side
//                         (drives rx flit / pop request, sees heads/credits)
//                slave  : the VC buffer itself
//  Signals     : rx_flit_v_i / rx_flit_i / rx_flit_vc_id_i /
//                rx_flit_look_ahead_routing_i  - incoming flit
//                inport_read_enable_st_stage_i / inport_read_vc_id_st_stage_i
//                                              - pop request
//                vc_data_head_o / vc_look_ahead_routing_o / vc_head_vld_o
//                                              - per-VC head view
//                rx_lcrd_v_o / rx_lcrd_id_o    - credit return upstream
//                err_overflow_o / err_underflow_o - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_port_vc_buffer_if #(
   parameter int VC_NUM   = 4,
   parameter int FLIT_W   = 256,
   parameter int VC_ID_W  = 3,
   parameter int LAR_W    = 3
) ();
   logic                      rx_flit_v_i;
   logic [FLIT_W-1:0]         rx_flit_i;
   logic [VC_ID_W-1:0]        rx_flit_vc_id_i;
   logic [LAR_W-1:0]          rx_flit_look_ahead_routing_i;
   logic                      inport_read_enable_st_stage_i;
   logic [VC_ID_W-1:0]        inport_read_vc_id_st_stage_i;
   logic [VC_NUM*FLIT_W-1:0]  vc_data_head_o;
   logic [VC_NUM*LAR_W-1:0]   vc_look_ahead_routing_o;
   logic [VC_NUM-1:0]         vc_head_vld_o;
   logic                      rx_lcrd_v_o;
   logic [VC_ID_W-1:0]        rx_lcrd_id_o;
   logic                      err_overflow_o;
   logic                      err_underflow_o;

   modport master (
      output rx_flit_v_i, rx_flit_i, rx_flit_vc_id_i, rx_flit_look_ahead_routing_i,
      output inport_read_enable_st_stage_i, inport_read_vc_id_st_stage_i,
      input  vc_data_head_o, vc_look_ahead_routing_o, vc_head_vld_o,
      input  rx_lcrd_v_o, rx_lcrd_id_o, err_overflow_o, err_underflow_o
   );

   modport slave (
      input  rx_flit_v_i, rx_flit_i, rx_flit_vc_id_i, rx_flit_look_ahead_routing_i,
      input  inport_read_enable_st_stage_i, inport_read_vc_id_st_stage_i,
      output vc_data_head_o, vc_look_ahead_routing_o, vc_head_vld_o,
      output rx_lcrd_v_o, rx_lcrd_id_o, err_overflow_o, err_underflow_o
   );
endinterface
`default_nettype wire

// File: rtl/input_port_vc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_vc_buffer
//  Description : Per-input-port virtual-channel flit buffer. One circular
//                FIFO per VC with first-word-fall-through head outputs; each
//                accepted switch-traversal pop returns one registered credit.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - synchronous active-high reset
//                bus  - input_port_vc_buffer_if.slave (flit in, pop request,
//                       per-VC heads, credit return, error flags)
//  Options     : `define NOC_VC_BUF_ERR_CHK_EN to build the sticky
//                overflow/underflow detectors; otherwise both flags read 0.
//                Illegal writes/reads are dropped in either build.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_port_vc_buffer #(
   parameter int VC_NUM   = 4,
   parameter int VC_DEPTH = 4,
   parameter int FLIT_W   = 256,
   parameter int VC_ID_W  = 3,
   parameter int LAR_W    = 3
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input_port_vc_buffer_if.slave bus
);

   localparam int c_PTR_W = $clog2(VC_DEPTH);
   localparam int c_CNT_W = $clog2(VC_DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(VC_DEPTH);

   // Per-VC accept strobes. A VC id >= VC_NUM matches no VC, so it is
   // rejected for free by the OR-reduction below.
   logic [VC_NUM-1:0] w_wr_acc;
   logic [VC_NUM-1:0] w_rd_acc;
   logic              w_any_rd;

   logic              r_lcrd_v;
   logic [VC_ID_W-1:0] r_lcrd_id;

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic [FLIT_W-1:0]  r_flit_mem [VC_DEPTH];
      logic [LAR_W-1:0]   r_lar_mem  [VC_DEPTH];
      logic [c_PTR_W-1:0] r_wr_ptr;
      logic [c_PTR_W-1:0] r_rd_ptr;
      logic [c_CNT_W-1:0] r_cnt;
      logic               w_wr_hit;
      logic               w_rd_hit;

      assign w_wr_hit    = bus.rx_flit_v_i &&
                           (bus.rx_flit_vc_id_i == VC_ID_W'(v));
      assign w_rd_hit    = bus.inport_read_enable_st_stage_i &&
                           (bus.inport_read_vc_id_st_stage_i == VC_ID_W'(v));
      assign w_wr_acc[v] = w_wr_hit && (r_cnt != c_FULL);
      // Read qualified by the pre-edge count, so a same-cycle write into an
      // empty VC cannot satisfy the read.
      assign w_rd_acc[v] = w_rd_hit && (r_cnt != '0);

      // Storage carries no reset; validity comes from r_cnt.
      always_ff @(posedge clk) begin
         if (w_wr_acc[v]) begin
            r_flit_mem[r_wr_ptr] <= bus.rx_flit_i;
            r_lar_mem[r_wr_ptr]  <= bus.rx_flit_look_ahead_routing_i;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
         end else begin
            if (w_wr_acc[v]) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_rd_acc[v]) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_wr_acc[v], w_rd_acc[v]})
               2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
               2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
               default: r_cnt <= r_cnt;
            endcase
         end
      end

      assign bus.vc_data_head_o[v*FLIT_W +: FLIT_W]        = r_flit_mem[r_rd_ptr];
      assign bus.vc_look_ahead_routing_o[v*LAR_W +: LAR_W] = r_lar_mem[r_rd_ptr];
      assign bus.vc_head_vld_o[v]                          = (r_cnt != '0);
   end

   assign w_any_rd = |w_rd_acc;

   // At most one pop per cycle, so at most one credit; it is registered and
   // a pop coinciding with reset is dropped along with the buffer contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lcrd_v  <= 1'b0;
         r_lcrd_id <= '0;
      end else begin
         r_lcrd_v <= w_any_rd;
         if (w_any_rd) r_lcrd_id <= bus.inport_read_vc_id_st_stage_i;
      end
   end

   assign bus.rx_lcrd_v_o  = r_lcrd_v;
   assign bus.rx_lcrd_id_o = r_lcrd_id;

`ifdef NOC_VC_BUF_ERR_CHK_EN
   logic w_ovf_evt;
   logic w_udf_evt;
   logic r_err_ovf;
   logic r_err_udf;

   // Any request not accepted by some VC is either full/empty or out of range.
   assign w_ovf_evt = bus.rx_flit_v_i && !(|w_wr_acc);
   assign w_udf_evt = bus.inport_read_enable_st_stage_i && !w_any_rd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_ovf <= 1'b0;
         r_err_udf <= 1'b0;
      end else begin
         if (w_ovf_evt) r_err_ovf <= 1'b1;
         if (w_udf_evt) r_err_udf <= 1'b1;
      end
   end

   assign bus.err_overflow_o  = r_err_ovf;
   assign bus.err_underflow_o = r_err_udf;
`else
   assign bus.err_overflow_o  = 1'b0;
   assign bus.err_underflow_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_port_vc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_port_vc_buffer
//  Description : Directed self-checking bench for input_port_vc_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_port_vc_buffer;

   localparam int VC_NUM   = 4;
   localparam int VC_DEPTH = 4;
   localparam int FLIT_W   = 256;
   localparam int VC_ID_W  = 3;
   localparam int LAR_W    = 3;

`ifdef NOC_VC_BUF_ERR_CHK_EN
   localparam logic c_ERR = 1'b1;
`else
   localparam logic c_ERR = 1'b0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   ncred;

   input_port_vc_buffer_if #(
      .VC_NUM (VC_NUM),
      .FLIT_W (FLIT_W),
      .VC_ID_W(VC_ID_W),
      .LAR_W  (LAR_W)
   ) bus ();

   input_port_vc_buffer #(
      .VC_NUM  (VC_NUM),
      .VC_DEPTH(VC_DEPTH),
      .FLIT_W  (FLIT_W),
      .VC_ID_W (VC_ID_W),
      .LAR_W   (LAR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change #1 after a rising edge; outputs are checked there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic v, input logic [2:0] id, input logic [255:0] d, input logic [2:0] lar);
      bus.rx_flit_v_i                  = v;
      bus.rx_flit_vc_id_i              = id;
      bus.rx_flit_i                    = d;
      bus.rx_flit_look_ahead_routing_i = lar;
   endtask

   task automatic rd(input logic en, input logic [2:0] id);
      bus.inport_read_enable_st_stage_i = en;
      bus.inport_read_vc_id_st_stage_i  = id;
   endtask

   function automatic logic [255:0] head(input int v);
      return bus.vc_data_head_o[v*FLIT_W +: FLIT_W];
   endfunction

   function automatic logic [2:0] lar(input int v);
      return bus.vc_look_ahead_routing_o[v*LAR_W +: LAR_W];
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      ncred = 0;
      rst   = 1'b1;
      wr(1'b0, 3'd0, '0, 3'd0);
      rd(1'b0, 3'd0);
      tick();
      tick();

      // ---- reset state
      chk("rst_vld",    256'(bus.vc_head_vld_o), 256'h0);
      chk("rst_lcrd_v", 256'(bus.rx_lcrd_v_o), 256'h0);
      chk("rst_lcrd_id",256'(bus.rx_lcrd_id_o), 256'h0);
      chk("rst_ovf",    256'(bus.err_overflow_o), 256'h0);
      chk("rst_udf",    256'(bus.err_underflow_o), 256'h0);
      rst = 1'b0;

      // ---- fill VC2 with A0..A3
      wr(1'b1, 3'd2, 256'hA0, 3'd1);
      tick();
      chk("fill_vld2",  256'(bus.vc_head_vld_o), 256'b0100);
      chk("fill_head2", head(2), 256'hA0);
      chk("fill_lar2",  256'(lar(2)), 256'd1);
      for (int i = 1; i < 4; i++) begin
         wr(1'b1, 3'd2, 256'hA0 + 256'(i), 3'(i + 1));
         tick();
      end
      chk("fill_ovf_pre", 256'(bus.err_overflow_o), 256'h0);
      wr(1'b1, 3'd2, 256'hA4, 3'd7);
      tick();
      wr(1'b0, 3'd0, '0, 3'd0);
      chk("fill5_ovf",  256'(bus.err_overflow_o), 256'(c_ERR));
      chk("fill5_head", head(2), 256'hA0);

      // ---- drain VC2
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", head(2), 256'hA0 + 256'(i));
         chk("drain_lar",  256'(lar(2)), 256'(i + 1));
         rd(1'b1, 3'd2);
         tick();
         chk("drain_lcrd_v",  256'(bus.rx_lcrd_v_o), 256'h1);
         chk("drain_lcrd_id", 256'(bus.rx_lcrd_id_o), 256'h2);
      end
      rd(1'b0, 3'd0);
      chk("drain_vld2", 256'(bus.vc_head_vld_o[2]), 256'h0);
      tick();
      chk("drain_idle_lcrd", 256'(bus.rx_lcrd_v_o), 256'h0);

      // ---- simultaneous read+write on VC1 holding two flits
      wr(1'b1, 3'd1, 256'hB0, 3'd2);
      tick();
      wr(1'b1, 3'd1, 256'hB1, 3'd3);
      tick();
      wr(1'b1, 3'd1, 256'hB2, 3'd4);
      rd(1'b1, 3'd1);
      tick();
      wr(1'b0, 3'd0, '0, 3'd0);
      chk("rw_lcrd_v",  256'(bus.rx_lcrd_v_o), 256'h1);
      chk("rw_lcrd_id", 256'(bus.rx_lcrd_id_o), 256'h1);
      chk("rw_head1",   head(1), 256'hB1);
      tick();
      chk("rw_head1_b", head(1), 256'hB2);
      chk("rw_vld1_b",  256'(bus.vc_head_vld_o[1]), 256'h1);
      tick();
      rd(1'b0, 3'd0);
      chk("rw_vld1_empty", 256'(bus.vc_head_vld_o[1]), 256'h0);
      chk("rw_udf_clean",  256'(bus.err_underflow_o), 256'h0);
      tick();

      // ---- read+write on empty VC0
      wr(1'b1, 3'd0, 256'hC0, 3'd5);
      rd(1'b1, 3'd0);
      tick();
      wr(1'b0, 3'd0, '0, 3'd0);
      rd(1'b0, 3'd0);
      chk("empty_lcrd_v", 256'(bus.rx_lcrd_v_o), 256'h0);
      chk("empty_udf",    256'(bus.err_underflow_o), 256'(c_ERR));
      chk("empty_vld0",   256'(bus.vc_head_vld_o[0]), 256'h1);
      chk("empty_head0",  head(0), 256'hC0);
      rd(1'b1, 3'd0);
      tick();
      rd(1'b0, 3'd0);
      chk("empty_pop_lcrd_id", 256'(bus.rx_lcrd_id_o), 256'h0);
      chk("empty_pop_vld0",    256'(bus.vc_head_vld_o[0]), 256'h0);

      // ---- pointer wrap on VC3: 10 writes and 10 reads, overlapped
      wr(1'b1, 3'd3, 256'hD0, 3'd0);
      tick();
      if (bus.rx_lcrd_v_o) ncred++;
      for (int i = 0; i < 10; i++) begin
         chk("wrap_head3", head(3), 256'hD0 + 256'(i));
         rd(1'b1, 3'd3);
         if (i < 9) wr(1'b1, 3'd3, 256'hD0 + 256'(i + 1), 3'((i + 1) % 8));
         else       wr(1'b0, 3'd0, '0, 3'd0);
         tick();
         if (bus.rx_lcrd_v_o && bus.rx_lcrd_id_o == 3'd3) ncred++;
      end
      rd(1'b0, 3'd0);
      tick();
      if (bus.rx_lcrd_v_o) ncred++;
      chk("wrap_credits", 256'(ncred), 256'd10);
      chk("wrap_vld3",    256'(bus.vc_head_vld_o[3]), 256'h0);

      // ---- illegal VC id write, then reset during a pop
      wr(1'b1, 3'd1, 256'hE0, 3'd1);
      tick();
      wr(1'b1, 3'd1, 256'hE1, 3'd2);
      tick();
      wr(1'b1, 3'd6, 256'hEE, 3'd3);
      tick();
      wr(1'b0, 3'd0, '0, 3'd0);
      chk("illegal_vld", 256'(bus.vc_head_vld_o), 256'b0010);
      chk("illegal_head1", head(1), 256'hE0);
      rd(1'b1, 3'd1);
      rst = 1'b1;
      tick();
      rd(1'b0, 3'd0);
      rst = 1'b0;
      chk("mrst_lcrd_v", 256'(bus.rx_lcrd_v_o), 256'h0);
      chk("mrst_vld",    256'(bus.vc_head_vld_o), 256'h0);
      chk("mrst_ovf",    256'(bus.err_overflow_o), 256'h0);
      chk("mrst_udf",    256'(bus.err_underflow_o), 256'h0);
      tick();
      chk("mrst_lcrd_v2", 256'(bus.rx_lcrd_v_o), 256'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/input_port_vc_buffer.md
# input_port_vc_buffer

Per-input-port virtual-channel flit buffer of the NoC router. It receives flits from the upstream link into one FIFO per VC and presents each VC's head flit and head look-ahead route to the switch-allocation and switch-traversal stages. On each switch-traversal read it pops the selected VC and returns one credit upstream. One instance per router input port (N/S/E/W/L); its `vc_data_head_o` feeds the crossbar's `vc_data_head_from*_i` input for that port.

## Interface
Parameters:
- `VC_NUM`, 4: number of VCs on this input port (1..6).
- `VC_DEPTH`, 4: flit slots per VC (power of two, ≥2).
- `FLIT_W`, 256: flit width in bits.
- `VC_ID_W`, 3: VC id field width.
- `LAR_W`, 3: look-ahead routing field width.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rx_flit_v_i` in 1: incoming flit valid.
- `rx_flit_i` in `FLIT_W`: incoming flit.
- `rx_flit_vc_id_i` in `VC_ID_W`: target VC of the incoming flit.
- `rx_flit_look_ahead_routing_i` in `LAR_W`: look-ahead output port of the incoming flit.
- `inport_read_enable_st_stage_i` in 1: switch-traversal stage pops one flit.
- `inport_read_vc_id_st_stage_i` in `VC_ID_W`: VC to pop.
- `vc_data_head_o` out `VC_NUM*FLIT_W`: head flit per VC; VC v occupies bits [v*FLIT_W +: FLIT_W].
- `vc_look_ahead_routing_o` out `VC_NUM*LAR_W`: head look-ahead route per VC.
- `vc_head_vld_o` out `VC_NUM`: VC v is non-empty.
- `rx_lcrd_v_o` out 1: credit return valid to upstream.
- `rx_lcrd_id_o` out `VC_ID_W`: VC id of the returned credit.
- `err_overflow_o` out 1: sticky write-to-full or illegal VC id error.
- `err_underflow_o` out 1: sticky read-of-empty or illegal VC id error.

## Operation
- Each VC is a circular buffer with `clog2(VC_DEPTH)`-bit read and write pointers. Pointers wrap naturally from `VC_DEPTH-1` to 0.
- Each VC has an occupancy counter of width `clog2(VC_DEPTH+1)`.
- **Write:** when `rx_flit_v_i=1`, `rx_flit_vc_id_i<VC_NUM` and the VC's count is below `VC_DEPTH`:
  - store the flit and route at the write pointer;
  - increment the write pointer;
  - increment the count.
- **Read:** when `inport_read_enable_st_stage_i=1`, the VC id is below `VC_NUM` and the VC's count is above 0:
  - increment the read pointer;
  - decrement the count.
- **Simultaneous write and read, same VC, count>0:** both take effect; count is unchanged.
- **Simultaneous write and read, same VC, count=0:** the write is accepted; the read is rejected as an underflow.
- **Write to a full VC, or VC id ≥ `VC_NUM`:** the flit is dropped, no state changes, and `err_overflow_o` is set.
- **Read of an empty VC, or VC id ≥ `VC_NUM`:** ignored, no credit is returned, and `err_underflow_o` is set.
- **Head outputs:** combinational from storage at the read pointer (first-word fall-through). When a VC is empty, `vc_head_vld_o[v]=0`; head data is don't-care but stable.
- **Credit return:** every accepted read produces exactly one credit, registered. `rx_lcrd_v_o=1` and `rx_lcrd_id_o`=the popped VC id appear in the following cycle. At most one credit is returned per cycle.

## Timing
- **Reset values:**
  - all pointers and counts 0;
  - `vc_head_vld_o=0`;
  - `rx_lcrd_v_o=0`, `rx_lcrd_id_o=0`;
  - both error flags 0.
  - Flit storage is not reset.
- Write to head visible: a flit written in cycle t appears on the head outputs, with `vc_head_vld_o` set, in cycle t+1.
- Read to credit: a read in cycle t gives `rx_lcrd_v_o=1` in cycle t+1. The next head is valid in cycle t+1.
- Back-to-back reads of one VC: one pop per cycle, sustained.
- Reset asserted mid-operation: all VCs are emptied at the next edge. A credit pending for that edge is discarded, not returned. Upstream re-initialises its credits on reset.

## Configuration
- `NOC_VC_BUF_ERR_CHK_EN`
  - **Defined:** error detection logic is present and `err_overflow_o`/`err_underflow_o` are sticky until `rst`.
  - **Undefined:** both error outputs are tied to 0. Illegal writes and reads are still dropped or ignored without state change.

## Test plan
- **Fill and visibility:** reset, then write 4 flits (0xA0..0xA3) into VC2 on consecutive cycles. Required:
  - `vc_head_vld_o[2]=1` from the cycle after the first write;
  - head=0xA0;
  - a 5th write is dropped and `err_overflow_o=1` (with the macro).
- **Drain and credits:** pop VC2 for 4 consecutive cycles. Required:
  - heads 0xA0, 0xA1, 0xA2, 0xA3 in order;
  - `rx_lcrd_v_o=1` with id=2 on 4 consecutive cycles, each one cycle after its pop;
  - `vc_head_vld_o[2]=0` afterwards.
- **Simultaneous read and write, one VC:** with VC1 holding 2 flits, write and read VC1 in the same cycle. Required: count stays 2, the next head is the 2nd flit, and one credit with id=1 is returned.
- **Empty-VC read plus write:** with VC0 empty, read and write VC0 in the same cycle. Required:
  - no credit;
  - `err_underflow_o=1`;
  - the flit appears at the head next cycle with `vc_head_vld_o[0]=1`.
- **Pointer wrap:** perform 10 interleaved write/read pairs on VC3. Required: data order is preserved across wraparound and exactly 10 credits are returned.
- **Mid-operation reset:** assert `rst` in the same cycle as a read of VC1. Required: no credit next cycle, all `vc_head_vld_o=0`, and error flags cleared.
